lsu_mem_ctrl: RTL and testbench
===============================

# lsu_mem_ctrl

Load/store controller between the pipeline's memory stage and the single-port, word-wide data memory, which has a 1-cycle synchronous read and write-first behaviour.
- Converts RISC-V byte, half and word loads and stores into memory transactions.
- Sub-word stores use read-modify-write.
- Loads are lane-extracted and sign- or zero-extended.
- Misaligned or illegal requests are rejected without touching memory.

## Interface
Parameters:
- ADDRESS_WIDTH, 10, word-address width of the attached memory (depth = 2^ADDRESS_WIDTH words of 32 bits)

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  controller can accept; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V width code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  load result; 0 for stores and errors
- rsp_err  out  1  misaligned or illegal request; valid with rsp_valid
- mem_we  out  1  memory write enable
- mem_addr  out  ADDRESS_WIDTH  word address, = req_addr[ADDRESS_WIDTH+1:2]; upper bits ignored (wrap)
- mem_din  out  32  memory write data
- mem_dout  in  32  memory read data; valid the cycle after mem_addr is presented with mem_we=0

## Operation
States:
- IDLE:
  - req_ready=1. On req_valid, latch we, funct3, addr, wdata.
  - Then go to one of:
    - ERR, if the request is illegal or misaligned
    - WR, for SW
    - RD, for all other legal requests
- RD: mem_addr=latched word address, mem_we=0. Go to DATA.
- DATA: mem_dout valid.
  - Load: register the extracted/extended result into rsp_rdata, then go to RESP.
  - Sub-word store: register the merged word into the write buffer, then go to WR.
- WR: mem_we=1, mem_din=write buffer (SW: latched wdata unchanged). Go to RESP.
- RESP: rsp_valid=1 for one cycle. Go to IDLE.
- ERR: rsp_valid=1, rsp_err=1, rsp_rdata=0. Go to IDLE. Memory is never accessed.

Rules:
- Illegal: store funct3 ∉ {000,001,010}; load funct3 ∈ {011,110,111}.
- Misaligned: H/HU/SH with addr[0]=1; W/SW with addr[1:0]≠00. Byte accesses are always aligned.
- Lanes are little-endian: byte n = bits [8n+7:8n]. The halfword lane is addr[1].
- Loads:
  - LB/LH sign-extend from bit 7 or 15 of the selected lane.
  - LBU/LHU zero-extend.
  - LW passes the word through.
- Sub-word store merge: replace only the selected lane with req_wdata[7:0] or req_wdata[15:0]. Other lanes keep the mem_dout value.
- mem_we is decoded from state only, so it is never high outside WR. mem_addr holds the latched address outside IDLE.
- No response backpressure. The consumer must accept rsp_valid when it pulses.

## Timing
- Accept edge = rising edge at which req_valid & req_ready.
- Latency from accept edge to the rsp_valid cycle:
  - load: 3 cycles
  - SB/SH: 4 cycles
  - SW: 2 cycles
  - error: 1 cycle
- Throughput: the next request can be accepted in the cycle after RESP/ERR (req_ready high again in IDLE).
- Reset values, while rst high or right after it: state IDLE, req_ready=0 during rst, then 1; rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_we=0, mem_addr=0, mem_din=0, all latches 0.
- Reset mid-operation: state returns to IDLE asynchronously and mem_we drops immediately. An in-progress RMW is abandoned; a write not yet performed is never performed. No rsp_valid is issued for the aborted request.
- req_valid while not ready is ignored. The requester must hold the request until accepted.

## Test plan
- Reset then LW: preload word 5 = 0x8081_82F3; LW addr 0x14 -> rsp_valid exactly 3 cycles after accept, rsp_rdata=0x8081_82F3, rsp_err=0.
- Sub-word loads from the same word:
  - LB addr 0x14 -> 0xFFFF_FFF3
  - LBU 0x14 -> 0x0000_00F3
  - LH 0x16 -> 0xFFFF_8081
  - LHU 0x16 -> 0x0000_8081
- SB addr 0x15, wdata 0xAAAA_AA5C over 0x1122_3344 -> exactly one mem_we pulse, 3 cycles after accept; word becomes 0x1122_5C44; rsp_valid 4 cycles after accept.
- SH addr 0x16, wdata 0x0000_BEEF -> word 0xBEEF_5C44. SW addr 0x18, wdata 0xDEAD_0001 -> mem_we in cycle 1 after accept, rsp 2 cycles after accept.
- Errors: LW addr 0x13, SH addr 0x15, load funct3=011 -> rsp_err=1 one cycle after accept, rsp_rdata=0, mem_we never asserted, memory unchanged.
- Assert rst during the RD state of an SB -> mem_we stays 0, no rsp_valid, target word unchanged. After release, an LW to the same address returns the original value.

Source files
------------

// File: rtl/lsu_mem_ctrl_if.sv
// Bundle between the pipeline memory stage, the load/store controller and the data memory.
interface lsu_mem_if #(
  parameter int unsigned ADDRESS_WIDTH = 10
);
  logic                     req_valid;
  logic                     req_ready;
  logic                     req_we;
  logic [2:0]               req_funct3;
  logic [31:0]              req_addr;
  logic [31:0]              req_wdata;
  logic                     rsp_valid;
  logic [31:0]              rsp_rdata;
  logic                     rsp_err;
  logic                     mem_we;
  logic [ADDRESS_WIDTH-1:0] mem_addr;
  logic [31:0]              mem_din;
  logic [31:0]              mem_dout;

  // Pipeline side: issues requests, consumes responses
  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  // Controller side: serves requests and drives the memory port
  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_dout,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_we, mem_addr, mem_din
  );

  // Data memory side
  modport mem (
    input  mem_we, mem_addr, mem_din,
    output mem_dout
  );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller: RISC-V B/H/W loads and stores onto a word-wide single-port
// memory with 1-cycle synchronous read; sub-word stores use read-modify-write.
module lsu_mem_ctrl #(
  parameter int unsigned ADDRESS_WIDTH = 10
) (
  input logic      clk,
  input logic      rst,
  lsu_mem_if.slave lsu_if
);
  localparam int unsigned AW = ADDRESS_WIDTH;
  localparam int unsigned LW = AW + 2;

  typedef enum logic [2:0] {IDLE, RD, DATA, WR, RESP, ERR} state_e;

  state_e         state_q;
  logic           we_q;
  logic [2:0]     funct3_q;
  logic [LW-1:0]  addr_q;
  logic [31:0]    wbuf_q;
  logic [31:0]    rdata_q;

  logic           ready_c;
  logic           accept_c;
  logic           illegal_c;
  logic           misalign_c;
  logic [7:0]     byte_c;
  logic [15:0]    half_c;
  logic [31:0]    rdata_d;
  logic [31:0]    wbuf_d;
  logic           unused_addr_bits;

  assign ready_c          = (state_q == IDLE) && !rst;
  assign accept_c         = lsu_if.req_valid && ready_c;
  assign unused_addr_bits = ^lsu_if.req_addr[31:LW];

  // Request classification, evaluated on the live request at the accept edge
  always_comb begin
    illegal_c  = 1'b0;
    misalign_c = 1'b0;
    if (lsu_if.req_we) begin
      illegal_c = (lsu_if.req_funct3 > 3'b010);
    end else begin
      illegal_c = (lsu_if.req_funct3 == 3'b011) || (lsu_if.req_funct3 == 3'b110) ||
                  (lsu_if.req_funct3 == 3'b111);
    end
    case (lsu_if.req_funct3[1:0])
      2'b01:   misalign_c = lsu_if.req_addr[0];
      2'b10:   misalign_c = |lsu_if.req_addr[1:0];
      default: misalign_c = 1'b0;
    endcase
  end

  // Lane extraction / extension for loads and lane merge for sub-word stores
  always_comb begin
    byte_c  = lsu_if.mem_dout[{addr_q[1:0], 3'b000} +: 8];
    half_c  = addr_q[1] ? lsu_if.mem_dout[31:16] : lsu_if.mem_dout[15:0];
    rdata_d = lsu_if.mem_dout;
    case (funct3_q)
      3'b000:  rdata_d = {{24{byte_c[7]}}, byte_c};
      3'b100:  rdata_d = {24'b0, byte_c};
      3'b001:  rdata_d = {{16{half_c[15]}}, half_c};
      3'b101:  rdata_d = {16'b0, half_c};
      default: rdata_d = lsu_if.mem_dout;
    endcase
    wbuf_d = lsu_if.mem_dout;
    if (funct3_q[1:0] == 2'b00) begin
      wbuf_d[{addr_q[1:0], 3'b000} +: 8] = wbuf_q[7:0];
    end else begin
      wbuf_d[{addr_q[1], 4'b0000} +: 16] = wbuf_q[15:0];
    end
  end

  // Control FSM; wbuf_q holds the store data until the merge replaces it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      wbuf_q   <= 32'h0;
      rdata_q  <= 32'h0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_c) begin
            we_q     <= lsu_if.req_we;
            funct3_q <= lsu_if.req_funct3;
            addr_q   <= lsu_if.req_addr[LW-1:0];
            wbuf_q   <= lsu_if.req_wdata;
            rdata_q  <= 32'h0;
            if (illegal_c || misalign_c) begin
              state_q <= ERR;
            end else if (lsu_if.req_we && (lsu_if.req_funct3 == 3'b010)) begin
              state_q <= WR;
            end else begin
              state_q <= RD;
            end
          end
        end
        RD:   state_q <= DATA;
        DATA: begin
          if (we_q) begin
            wbuf_q  <= wbuf_d;
            state_q <= WR;
          end else begin
            rdata_q <= rdata_d;
            state_q <= RESP;
          end
        end
        WR:      state_q <= RESP;
        RESP:    state_q <= IDLE;
        ERR:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign lsu_if.req_ready = ready_c;
  assign lsu_if.rsp_valid = (state_q == RESP) || (state_q == ERR);
  assign lsu_if.rsp_err   = (state_q == ERR);
  assign lsu_if.rsp_rdata = rdata_q;
  assign lsu_if.mem_we    = (state_q == WR);
  assign lsu_if.mem_addr  = addr_q[LW-1:2];
  assign lsu_if.mem_din   = wbuf_q;
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Scoreboard bench for lsu_mem_ctrl: requests push expected responses/writes from a
// word-array reference model; negedge monitors pop and compare.
module tb_lsu_mem_ctrl;
  localparam int unsigned AW    = 10;
  localparam int unsigned DEPTH = 1 << AW;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } rsp_exp_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    int            cyc;
  } wr_exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] mem_arr [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  rsp_exp_t    rsp_q [$];
  wr_exp_t     wr_q [$];
  logic [31:0] orig_word;
  logic [31:0] ra;
  logic [31:0] rwd;
  logic [2:0]  rf3;
  logic        rwe;
  int          mism;

  lsu_mem_if #(.ADDRESS_WIDTH(AW)) lif ();
  lsu_mem_ctrl #(.ADDRESS_WIDTH(AW)) dut (.clk(clk), .rst(rst), .lsu_if(lif));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Write-first synchronous single-port memory
  always @(posedge clk) begin
    if (lif.mem_we) mem_arr[lif.mem_addr] <= lif.mem_din;
    lif.mem_dout <= lif.mem_we ? lif.mem_din : mem_arr[lif.mem_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit legal(input logic we, input logic [2:0] f3, input logic [31:0] a);
    int sz;
    if (we && f3 > 3'd2) return 1'b0;
    if (!we && (f3 == 3'd3 || f3 >= 3'd6)) return 1'b0;
    sz = 1 << int'(f3[1:0]);
    return (int'(a[1:0]) % sz) == 0;
  endfunction

  task automatic poke(input int idx, input logic [31:0] d);
    mem_arr[idx] = d;
    ref_mem[idx] = d;
  endtask

  // Drive one request, wait for acceptance, and record what must come back
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd);
    int n = 0;
    int acc;
    int idx;
    int sh;
    logic [31:0] w;
    logic [31:0] v;
    logic [31:0] mask;
    rsp_exp_t r;
    wr_exp_t x;
    lif.req_valid  = 1'b1;
    lif.req_we     = we;
    lif.req_funct3 = f3;
    lif.req_addr   = a;
    lif.req_wdata  = wd;
    while (lif.req_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      check("req_ready_timeout", 32'(lif.req_ready), 32'd1);
      lif.req_valid = 1'b0;
      return;
    end
    acc = cyc;
    idx = int'(a[AW+1:2]);
    sh  = 8 * int'(a[1:0]);
    w   = ref_mem[idx];
    r.rdata = 32'h0;
    r.err   = 1'b0;
    if (!legal(we, f3, a)) begin
      r.err = 1'b1;
      r.cyc = acc + 1;
    end else if (!we) begin
      case (f3[1:0])
        2'd0: begin
          v = (w >> sh) & 32'hFF;
          if (!f3[2] && v >= 32'd128) v = v - 32'd256;
        end
        2'd1: begin
          v = (w >> sh) & 32'hFFFF;
          if (!f3[2] && v >= 32'h8000) v = v - 32'h10000;
        end
        default: v = w;
      endcase
      r.rdata = v;
      r.cyc   = acc + 3;
    end else begin
      mask = (f3 == 3'd0) ? 32'hFF : (f3 == 3'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
      mask = mask << sh;
      v = (w & ~mask) | ((wd << sh) & mask);
      ref_mem[idx] = v;
      x.addr = a[AW+1:2];
      x.data = v;
      x.cyc  = acc + ((f3 == 3'd2) ? 1 : 3);
      wr_q.push_back(x);
      r.cyc = acc + ((f3 == 3'd2) ? 2 : 4);
    end
    rsp_q.push_back(r);
    @(negedge clk);
    lif.req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((rsp_q.size() != 0 || wr_q.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("drain_timeout", 32'(rsp_q.size() + wr_q.size()), 32'd0);
    @(negedge clk);
  endtask

  // Response and memory-write monitor
  always @(negedge clk) begin : monitor
    rsp_exp_t r;
    wr_exp_t  w;
    if (lif.rsp_valid === 1'b1) begin
      if (rsp_q.size() == 0) begin
        check("rsp_unexpected", 32'(lif.rsp_valid), 32'd0);
      end else begin
        r = rsp_q.pop_front();
        check("rsp_rdata", lif.rsp_rdata, r.rdata);
        check("rsp_err", 32'(lif.rsp_err), 32'(r.err));
        check("rsp_cycle", 32'(cyc), 32'(r.cyc));
      end
    end
    if (lif.mem_we === 1'b1) begin
      if (wr_q.size() == 0) begin
        check("mem_we_unexpected", 32'(lif.mem_we), 32'd0);
      end else begin
        w = wr_q.pop_front();
        check("mem_addr", 32'(lif.mem_addr), 32'(w.addr));
        check("mem_din", lif.mem_din, w.data);
        check("mem_we_cycle", 32'(cyc), 32'(w.cyc));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    lif.req_valid  = 1'b0;
    lif.req_we     = 1'b0;
    lif.req_funct3 = 3'b000;
    lif.req_addr   = 32'h0;
    lif.req_wdata  = 32'h0;
    for (int i = 0; i < DEPTH; i++) begin
      mem_arr[i] = $urandom;
      ref_mem[i] = mem_arr[i];
    end
    poke(5, 32'h8081_82F3);

    repeat (2) @(negedge clk);
    check("rst_req_ready", 32'(lif.req_ready), 32'd0);
    check("rst_rsp_valid", 32'(lif.rsp_valid), 32'd0);
    check("rst_rsp_err", 32'(lif.rsp_err), 32'd0);
    check("rst_rsp_rdata", lif.rsp_rdata, 32'd0);
    check("rst_mem_we", 32'(lif.mem_we), 32'd0);
    check("rst_mem_addr", 32'(lif.mem_addr), 32'd0);
    check("rst_mem_din", lif.mem_din, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 32'(lif.req_ready), 32'd1);

    issue(1'b0, 3'b010, 32'h14, 32'h0);
    issue(1'b0, 3'b000, 32'h14, 32'h0);
    issue(1'b0, 3'b100, 32'h14, 32'h0);
    issue(1'b0, 3'b001, 32'h16, 32'h0);
    issue(1'b0, 3'b101, 32'h16, 32'h0);
    wait_drain();

    poke(5, 32'h1122_3344);
    issue(1'b1, 3'b000, 32'h15, 32'hAAAA_AA5C);
    issue(1'b1, 3'b001, 32'h16, 32'h0000_BEEF);
    issue(1'b1, 3'b010, 32'h18, 32'hDEAD_0001);
    issue(1'b0, 3'b010, 32'h13, 32'h0);
    issue(1'b1, 3'b001, 32'h15, 32'h1234_5678);
    issue(1'b0, 3'b011, 32'h14, 32'h0);
    wait_drain();
    check("word5_after_sb_sh", mem_arr[5], 32'hBEEF_5C44);
    check("word6_after_sw", mem_arr[6], 32'hDEAD_0001);

    // Abort an SB while it is reading the target word
    orig_word = mem_arr[7];
    lif.req_valid  = 1'b1;
    lif.req_we     = 1'b1;
    lif.req_funct3 = 3'b000;
    lif.req_addr   = 32'h1D;
    lif.req_wdata  = 32'h0000_00A5;
    check("abort_ready", 32'(lif.req_ready), 32'd1);
    @(negedge clk);
    lif.req_valid = 1'b0;
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("abort_mem_we", 32'(lif.mem_we), 32'd0);
      check("abort_rsp_valid", 32'(lif.rsp_valid), 32'd0);
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_word_kept", mem_arr[7], orig_word);
    issue(1'b0, 3'b010, 32'h1C, 32'h0);
    wait_drain();

    for (int k = 0; k < 400; k++) begin
      rwe = 1'($urandom_range(0, 1));
      rf3 = 3'($urandom_range(0, 7));
      ra  = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2) |
            32'($urandom_range(0, 3));
      rwd = $urandom;
      issue(rwe, rf3, ra, rwd);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    wait_drain();

    mism = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (mem_arr[i] !== ref_mem[i]) mism++;
    end
    check("final_mem_mismatch_words", 32'(mism), 32'd0);
    check("pending_expectations", 32'(rsp_q.size() + wr_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
